// File: rtl/key_repeat_conditioner_pkg.sv
// Shared constants for the key conditioner: key bit positions, repeat FSM
// state encoding and default timing.
package key_repeat_conditioner_pkg;

  localparam int NKEYS_DEF        = 6;
  localparam int DEB_TICKS_DEF    = 4;
  localparam int REPEAT_DELAY_DEF = 32;
  localparam int REPEAT_RATE_DEF  = 8;
  localparam int CW_DEF           = 6;

  // Bit positions inside keys_n / key_level / pending
  localparam int KEY_B    = 0;
  localparam int KEY_A    = 1;
  localparam int KEY_BTN0 = 2;
  localparam int KEY_BTN1 = 3;
  localparam int KEY_BTN2 = 4;
  localparam int KEY_BTN3 = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/key_repeat_conditioner_key_channel.sv
// One key: 2-flop synchronizer, tick-based debounce and auto-repeat FSM.
// o_event is combinational so the top can set pending on the same edge
// as the condition (the press event shares its edge with the level rise).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | key released, waiting for the debounced level to rise
// ST_DELAY  | pressed, counting towards the first repeat (saturates
//           | at the last count while repeat is disabled)
// ST_REPEAT | pressed, emitting an event every REPEAT_RATE ticks
module key_channel
  import key_repeat_conditioner_pkg::*;
#(
  parameter int DEB_TICKS    = DEB_TICKS_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
  parameter int CW           = CW_DEF
) (
  input  logic clock,
  input  logic rst,
  input  logic i_tick,
  input  logic i_key_n,
  input  logic i_en_repeat,
  output logic o_level,
  output logic o_event
);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_dcnt;
  logic [CW-1:0] r_rcnt;
  rep_state_t    r_state;

  logic w_differ;
  logic w_flip;
  logic w_rise;
  logic w_fall;
  logic w_event;

  assign w_differ = r_sync2 ^ r_level;
  assign w_flip   = i_tick & w_differ & (r_dcnt == DEB_LAST);
  assign w_rise   = w_flip & ~r_level;
  assign w_fall   = w_flip & r_level;

  // Bring the raw active-low button into the clock domain as active-high
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: level flips only after DEB_TICKS consecutive differing ticks
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_dcnt  <= '0;
    end else if (i_tick) begin
      if (!w_differ) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DEB_LAST) begin
        r_level <= ~r_level;
        r_dcnt  <= '0;
      end else begin
        r_dcnt <= r_dcnt + CW'(1);
      end
    end
  end

  // Event strobe; a release on this tick suppresses any repeat event.
  // Losing en_repeat on a REPEAT tick takes priority over the rate event.
  always_comb begin
    w_event = 1'b0;
    if (i_tick && !w_fall) begin
      case (r_state)
        ST_IDLE:   w_event = w_rise;
        ST_DELAY:  w_event = i_en_repeat && (r_rcnt == RD_LAST);
        ST_REPEAT: w_event = i_en_repeat && (r_rcnt == RR_LAST);
        default:   w_event = 1'b0;
      endcase
    end
  end

  // Repeat FSM and its tick counter
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_rcnt  <= '0;
    end else if (w_fall) begin
      r_state <= ST_IDLE;
      r_rcnt  <= '0;
    end else if (i_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_DELAY;
            r_rcnt  <= '0;
          end
        end
        ST_DELAY: begin
          if (r_rcnt == RD_LAST) begin
            if (i_en_repeat) begin
              r_state <= ST_REPEAT;
              r_rcnt  <= '0;
            end
          end else begin
            r_rcnt <= r_rcnt + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (!i_en_repeat) begin
            r_state <= ST_DELAY;
            r_rcnt  <= RD_LAST;
          end else if (r_rcnt == RR_LAST) begin
            r_rcnt <= '0;
          end else begin
            r_rcnt <= r_rcnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rcnt  <= '0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_event = w_event;

endmodule

// File: rtl/key_repeat_conditioner.sv
// Key input stage: one key_channel per button, sticky pending flags and an
// irq/ack handshake that always presents the highest-index pending key.
module key_repeat_conditioner
  import key_repeat_conditioner_pkg::*;
#(
  parameter int NKEYS        = NKEYS_DEF,
  parameter int DEB_TICKS    = DEB_TICKS_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
  parameter int CW           = CW_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             tick,
  input  logic [NKEYS-1:0] keys_n,
  input  logic             en_repeat,
  input  logic             ack,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] pending,
  output logic             irq,
  output logic [2:0]       irq_key
);

  logic [NKEYS-1:0] r_pending;
  logic [NKEYS-1:0] w_event;
  logic [NKEYS-1:0] w_clr;
  logic [2:0]       w_irq_key;
  logic             w_irq;

  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    key_channel #(
      .DEB_TICKS   (DEB_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CW          (CW)
    ) u_ch (
      .clock      (clock),
      .rst        (rst),
      .i_tick     (tick),
      .i_key_n    (keys_n[g]),
      .i_en_repeat(en_repeat),
      .o_level    (key_level[g]),
      .o_event    (w_event[g])
    );
  end

  // Highest set pending bit wins; later iterations override earlier ones
  always_comb begin
    w_irq_key = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (r_pending[i]) w_irq_key = 3'(i);
    end
  end

  assign w_irq = |r_pending;

  // Ack clears only the key currently presented, and only if one is
  always_comb begin
    w_clr = '0;
    if (ack && w_irq) w_clr[w_irq_key] = 1'b1;
  end

  // Sticky flags: a same-clock event on the acked key wins over the clear
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= (r_pending & ~w_clr) | w_event;
  end

  assign pending = r_pending;
  assign irq     = w_irq;
  assign irq_key = w_irq_key;

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Bench for key_repeat_conditioner: directed scenarios plus a random phase,
// all checked every clock against a timestamp-based behavioural model.
module tb_key_repeat_conditioner;
  import key_repeat_conditioner_pkg::*;

  localparam int DEB   = 4;
  localparam int RDLY  = 32;
  localparam int RRATE = 8;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] keys_n = 6'h3f;
  logic       en_repeat = 1'b0;
  logic       ack = 1'b0;
  logic [5:0] key_level;
  logic [5:0] pending;
  logic       irq;
  logic [2:0] irq_key;

  key_repeat_conditioner dut (
    .clock    (clock),
    .rst      (rst),
    .tick     (tick),
    .keys_n   (keys_n),
    .en_repeat(en_repeat),
    .ack      (ack),
    .key_level(key_level),
    .pending  (pending),
    .irq      (irq),
    .irq_key  (irq_key)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(negedge clock) begin
    cyc++;
    tick = (cyc % 4 == 0);
  end

  // ---------------- behavioural model ----------------
  // Timing is tracked with absolute tick timestamps: a held key is due an
  // event once the global tick index reaches its due time.
  logic [5:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_pend = '0;
  int m_streak[6];
  int m_mode[6];      // 0 released, 1 waiting first repeat, 2 repeating
  int m_due[6];
  int m_ticks = 0;
  int m_evq[6][$];    // tick index of every event, per key

  function automatic int top_idx(logic [5:0] v);
    for (int i = 5; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock) begin
    logic [5:0] ev;
    ev = '0;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0;
      for (int k = 0; k < 6; k++) begin
        m_streak[k] = 0; m_mode[k] = 0; m_due[k] = 0;
      end
    end else begin
      if (tick) begin
        for (int k = 0; k < 6; k++) begin
          if (m_s2[k] != m_level[k]) m_streak[k]++; else m_streak[k] = 0;
          if (m_streak[k] == DEB) begin
            m_streak[k] = 0;
            m_level[k] = ~m_level[k];
            if (m_level[k]) begin
              ev[k] = 1'b1; m_mode[k] = 1; m_due[k] = m_ticks + RDLY;
            end else m_mode[k] = 0;
          end else if (m_mode[k] == 1) begin
            if (en_repeat && m_ticks >= m_due[k]) begin
              ev[k] = 1'b1; m_mode[k] = 2; m_due[k] = m_ticks + RRATE;
            end
          end else if (m_mode[k] == 2) begin
            if (!en_repeat) begin
              m_mode[k] = 1; m_due[k] = m_ticks + 1;
            end else if (m_ticks >= m_due[k]) begin
              ev[k] = 1'b1; m_due[k] = m_ticks + RRATE;
            end
          end
          if (ev[k]) m_evq[k].push_back(m_ticks);
        end
        m_ticks++;
      end
      if (ack && m_pend != 0) m_pend[top_idx(m_pend)] = 1'b0;
      m_pend = m_pend | ev;
      m_s2 = m_s1;
      m_s1 = ~keys_n;
    end
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge clock);
      #1;
      chk("key_level", int'(key_level), int'(m_level));
      chk("pending", int'(pending), int'(m_pend));
      chk("irq", int'(irq), int'(|m_pend));
      chk("irq_key", int'(irq_key), top_idx(m_pend));
    end
  endtask

  function automatic int ev_at(int k, int i);
    if (i >= 0 && i < m_evq[k].size()) return m_evq[k][i];
    return -100000;
  endfunction

  task automatic step(input bit auto_ack = 1'b0);
    @(negedge clock);
    #1;
    if (auto_ack) ack = irq;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic wait_event(int k, int base, bit auto_ack);
    int n = 0;
    while (m_evq[k].size() <= base && n < 200) begin
      step(auto_ack);
      n++;
    end
    chk("wait_event", int'(m_evq[k].size() > base), 1);
  endtask

  task automatic run_until_ticks(int target, bit auto_ack);
    int n = 0;
    while (m_ticks < target && n < 2000) begin
      step(auto_ack);
      n++;
    end
    chk("wait_ticks", m_ticks, target);
  endtask

  initial begin
    int base, t0, r;
    fork compare_loop(); join_none

    // Reset state
    repeat (3) step();
    chk("rst_level", int'(key_level), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_irq", int'({irq, irq_key}), 0);
    rst = 1'b1;
    repeat (8) step();

    // Glitch of two ticks on key A
    keys_n[KEY_A] = 1'b0;
    repeat (8) step();
    keys_n[KEY_A] = 1'b1;
    repeat (30) step();
    chk("glitch_level", int'(key_level), 0);
    chk("glitch_pending", int'(pending), 0);

    // Clean press, no repeat
    en_repeat = 1'b0;
    base = m_evq[KEY_BTN3].size();
    keys_n[KEY_BTN3] = 1'b0;
    repeat (12) step();
    chk("press_early", int'(key_level[KEY_BTN3]), 0);
    repeat (8) step();
    chk("press_level", int'(key_level[KEY_BTN3]), 1);
    chk("press_pending", int'(pending), 6'h20);
    chk("press_irq", int'({irq, irq_key}), 4'b1101);
    ack_pulse();
    chk("press_ack", int'(pending), 0);
    repeat (400) step();
    chk("norep_pending", int'(pending), 0);
    chk("norep_events", m_evq[KEY_BTN3].size() - base, 1);
    keys_n[KEY_BTN3] = 1'b1;
    repeat (30) step();

    // Auto-repeat on key B: press at T, repeats at T+32, T+40, T+48
    en_repeat = 1'b1;
    base = m_evq[KEY_B].size();
    keys_n[KEY_B] = 1'b0;
    wait_event(KEY_B, base, 1'b1);
    t0 = ev_at(KEY_B, base);
    run_until_ticks(t0 + 50, 1'b1);
    chk("rep_count", m_evq[KEY_B].size() - base, 4);
    chk("rep_first", ev_at(KEY_B, base + 1) - t0, 32);
    chk("rep_second", ev_at(KEY_B, base + 2) - t0, 40);
    chk("rep_third", ev_at(KEY_B, base + 3) - t0, 48);
    keys_n[KEY_B] = 1'b1;
    repeat (60) step(1'b1);

    // Release at T+36 kills the T+40 repeat
    base = m_evq[KEY_B].size();
    keys_n[KEY_B] = 1'b0;
    wait_event(KEY_B, base, 1'b1);
    t0 = ev_at(KEY_B, base);
    run_until_ticks(t0 + 37, 1'b1);
    keys_n[KEY_B] = 1'b1;
    repeat (40) step(1'b1);
    chk("rel_count", m_evq[KEY_B].size() - base, 2);
    chk("rel_level", int'(key_level[KEY_B]), 0);

    // Re-press restarts the full delay
    base = m_evq[KEY_B].size();
    keys_n[KEY_B] = 1'b0;
    wait_event(KEY_B, base, 1'b1);
    t0 = ev_at(KEY_B, base);
    run_until_ticks(t0 + 34, 1'b1);
    chk("repress_count", m_evq[KEY_B].size() - base, 2);
    chk("repress_first", ev_at(KEY_B, base + 1) - t0, 32);
    keys_n[KEY_B] = 1'b1;
    ack = 1'b0;
    repeat (60) step(1'b1);
    ack = 1'b0;

    // Priority: keys B and BTN2 together
    en_repeat = 1'b0;
    keys_n[KEY_B] = 1'b0;
    keys_n[KEY_BTN2] = 1'b0;
    repeat (30) step();
    chk("prio_key", int'(irq_key), 4);
    chk("prio_pending", int'(pending), 6'h11);
    ack_pulse();
    chk("prio_key2", int'(irq_key), 0);
    chk("prio_pending2", int'(pending), 6'h01);
    ack_pulse();
    chk("prio_irq_off", int'(irq), 0);
    ack_pulse();
    chk("prio_idle_ack", int'(pending), 0);
    keys_n = 6'h3f;
    repeat (30) step();

    // Ack on the same clock as a repeat event of the same key
    en_repeat = 1'b1;
    base = m_evq[KEY_BTN1].size();
    keys_n[KEY_BTN1] = 1'b0;
    wait_event(KEY_BTN1, base, 1'b0);
    t0 = ev_at(KEY_BTN1, base);
    run_until_ticks(t0 + 32, 1'b0);
    for (int n = 0; n < 8 && !tick; n++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("collide_pending", int'(pending[KEY_BTN1]), 1);
    chk("collide_events", m_evq[KEY_BTN1].size() - base, 2);

    // Async reset mid-DELAY, key still held
    en_repeat = 1'b0;
    repeat (8) step();
    rst = 1'b0;
    #1;
    chk("arst_level", int'(key_level), 0);
    chk("arst_pending", int'(pending), 0);
    chk("arst_irq", int'({irq, irq_key}), 0);
    repeat (3) step();
    rst = 1'b1;
    r = m_ticks;
    base = m_evq[KEY_BTN1].size();
    wait_event(KEY_BTN1, base, 1'b0);
    chk("arst_repress_lat",
        int'(ev_at(KEY_BTN1, base) - r >= 3 && ev_at(KEY_BTN1, base) - r <= 4), 1);
    step();
    chk("arst_repress_pend", int'(pending[KEY_BTN1]), 1);
    keys_n = 6'h3f;
    repeat (40) step(1'b1);
    ack = 1'b0;

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 6; k++) if ($urandom_range(47) == 0) keys_n[k] = ~keys_n[k];
      if ($urandom_range(399) == 0) en_repeat = ~en_repeat;
      ack = ($urandom_range(4) == 0);
      step();
    end
    keys_n = 6'h3f;
    ack = 1'b0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
